door_limit_tracker: RTL and testbench

DOOR_LIMIT_TRACKER -- requirements
Module: door_limit_tracker

---
 rtl/door_limit_tracker_if.sv | 25 ++
 rtl/door_limit_tracker.sv | 108 ++++++++++
 tb/tb_door_limit_tracker.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/door_limit_tracker_if.sv
// Command/status bundle between the door controller and the limit tracker.
// The controller side is the master; the tracker is the slave.
interface door_limit_tracker_if;
   logic       open_cmd;
   logic       close_cmd;
   logic       pp;
   logic       clear_fault;
   logic [3:0] pos;
   logic       lim_open;
   logic       lim_closed;
   logic       moving;
   logic       dir;
   logic       obstruct;
   logic       fault;

   modport master (
      output open_cmd, close_cmd, pp, clear_fault,
      input  pos, lim_open, lim_closed, moving, dir, obstruct, fault
   );

   modport slave (
      input  open_cmd, close_cmd, pp, clear_fault,
      output pos, lim_open, lim_closed, moving, dir, obstruct, fault
   );
endinterface

// File: rtl/door_limit_tracker.sv
// Door position model: steps pos toward open/closed from motor commands
// and derives the limit switches the controller sees.
module door_limit_tracker #(
   parameter int unsigned TRAVEL   = 15,
   parameter int unsigned PRESCALE = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   door_limit_tracker_if.slave  bus
);

   localparam logic [3:0] TRAVEL_POS = 4'(TRAVEL);
   localparam logic [3:0] PS_LAST    = 4'(PRESCALE - 1);

   typedef enum logic [1:0] {IDLE, OPENING, CLOSING, FAULT} state_t;

   state_t     state_q, state_d;
   logic [3:0] pos_q, pos_d;
   logic [3:0] presc_q, presc_d;
   logic       obstruct_q, obstruct_d;
   logic       both, op, cl, step, lim_open, lim_closed;

   assign both       = bus.open_cmd & bus.close_cmd;
   assign op         = bus.open_cmd & ~bus.close_cmd;
   assign cl         = bus.close_cmd & ~bus.open_cmd;
   assign lim_open   = (pos_q == TRAVEL_POS);
   assign lim_closed = (pos_q == 4'd0);
   assign step       = (presc_q == PS_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pos_q      <= '0;
         presc_q    <= '0;
         obstruct_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         presc_q    <= presc_d;
         obstruct_q <= obstruct_d;
      end
   end

   // presc_d defaults to 0, so any exit from a motion state restarts the count.
   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      presc_d    = '0;
      obstruct_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (both)
               state_d = FAULT;
            else if (op && !lim_open)
               state_d = OPENING;
            else if (cl && !lim_closed && !bus.pp)
               state_d = CLOSING;
         end
         OPENING: begin
            if (both)
               state_d = FAULT;
            else if (!op)
               state_d = IDLE;
            else if (step) begin
               if (pos_q >= TRAVEL_POS - 4'd1) begin
                  pos_d   = TRAVEL_POS;
                  state_d = IDLE;
               end else begin
                  pos_d = pos_q + 4'd1;
               end
            end else
               presc_d = presc_q + 4'd1;
         end
         CLOSING: begin
            if (both)
               state_d = FAULT;
            else if (bus.pp) begin
               state_d    = IDLE;
               obstruct_d = 1'b1;
            end else if (!cl)
               state_d = IDLE;
            else if (step) begin
               if (pos_q <= 4'd1) begin
                  pos_d   = '0;
                  state_d = IDLE;
               end else begin
                  pos_d = pos_q - 4'd1;
               end
            end else
               presc_d = presc_q + 4'd1;
         end
         FAULT: begin
            if (bus.clear_fault && !bus.open_cmd && !bus.close_cmd)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.pos        = pos_q;
   assign bus.lim_open   = lim_open;
   assign bus.lim_closed = lim_closed;
   assign bus.moving     = (state_q == OPENING) || (state_q == CLOSING);
   assign bus.dir        = (state_q == OPENING);
   assign bus.obstruct   = obstruct_q;
   assign bus.fault      = (state_q == FAULT);

endmodule

// File: tb/tb_door_limit_tracker.sv
// Self-checking bench for door_limit_tracker with TRAVEL=15, PRESCALE=4.
module tb_door_limit_tracker;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   door_limit_tracker_if dif();

   door_limit_tracker #(.TRAVEL(15), .PRESCALE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif.slave)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic o, c, p, f;
      int   n;
      int   pos;
      logic mov, dir, obs, flt, lo, lc;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic o, input logic c, input logic p, input logic f);
      dif.open_cmd    = o;
      dif.close_cmd   = c;
      dif.pp          = p;
      dif.clear_fault = f;
   endtask

   task automatic chk_all(input string tag, input int pos, input logic mov, input logic dir,
                          input logic obs, input logic flt, input logic lo, input logic lc);
      chk({tag, ".pos"},        int'(dif.pos),        pos);
      chk({tag, ".moving"},     int'(dif.moving),     int'(mov));
      chk({tag, ".dir"},        int'(dif.dir),        int'(dir));
      chk({tag, ".obstruct"},   int'(dif.obstruct),   int'(obs));
      chk({tag, ".fault"},      int'(dif.fault),      int'(flt));
      chk({tag, ".lim_open"},   int'(dif.lim_open),   int'(lo));
      chk({tag, ".lim_closed"}, int'(dif.lim_closed), int'(lc));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //            o     c     p     f     n   pos mov   dir   obs   flt   lo    lc
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3,  9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2,  5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1,  5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 20, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 20, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      // reset values
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #12;
      chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      reset = 1'b1;

      // full open run: one step every 4 cycles, limit at 60 cycles
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("open_entry", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int c = 1; c <= 60; c++) begin
         tick();
         chk($sformatf("open_c%0d.pos", c), int'(dif.pos), c / 4);
         if (c < 60)
            chk($sformatf("open_c%0d.lim_open", c), int'(dif.lim_open), 0);
      end
      chk_all("open_done", 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();
      chk_all("open_push_limit", 15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // close from 15 aborted by pp at pos 9
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("close_entry", 15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (24) tick();
      chk_all("close_at9", 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk_all("pp_abort", 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("pp_after", 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();

      // table: fault entry/exit, close to closed limit, push against it
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].o, vecs[i].c, vecs[i].p, vecs[i].f);
         repeat (vecs[i].n) tick();
         chk_all($sformatf("vec%0d", i), vecs[i].pos, vecs[i].mov, vecs[i].dir,
                 vecs[i].obs, vecs[i].flt, vecs[i].lo, vecs[i].lc);
      end

      // open dropped at prescale count 2, count restarts on re-entry
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("drop_idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("reentry", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) tick();
      chk("reentry_c3.pos", int'(dif.pos), 0);
      tick();
      chk("reentry_c4.pos", int'(dif.pos), 1);
      repeat (24) tick();
      chk_all("open_to7", 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // asynchronous reset mid-close at pos 7
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      tick();
      chk_all("close_from7", 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      reset = 1'b0;
      #1;
      chk_all("async_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
